// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side prefetch block.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  // Encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  function automatic logic [1:0] occ_count(input occ_t o);
    return 2'(o);
  endfunction

endpackage

// File: rtl/fifo_rd_prefetch.sv
// Read-side FIFO consumer: turns the r_en/data_out/empty pull interface into a
// valid/ready stream through a 2-entry (head/skid) prefetch buffer.
module fifo_rd_prefetch
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  occ_t                  r_occ;
  occ_t                  w_occ_nxt;
  logic                  r_inflight;
  logic                  r_drop;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic                  w_pop;
  logic                  w_cap;
  logic [2:0]            w_level;

  assign m_valid  = (r_occ != OCC_EMPTY);
  assign m_data   = r_head;
  assign word_cnt = r_word_cnt;

  assign w_pop = m_valid & m_ready;
  // A word landing during flush is discarded along with the buffer contents.
  assign w_cap = r_inflight & ~r_drop & ~flush;

  // Projected occupancy after this cycle, counting the word already in flight.
  assign w_level   = {1'b0, occ_count(r_occ)} + {2'b00, r_inflight} - {2'b00, w_pop};
  // rrst_n gating keeps the FIFO untouched while reset is held.
  assign fifo_r_en = rrst_n & ~fifo_empty & ~flush & (w_level < 3'd2);

  // Next occupancy and head/skid contents from capture and pop.
  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_skid_nxt = r_skid;
    if (flush) begin
      w_occ_nxt = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_cap) begin
            w_head_nxt = fifo_data;
            w_occ_nxt  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_cap && w_pop) begin
            w_head_nxt = fifo_data;
          end else if (w_cap) begin
            w_skid_nxt = fifo_data;
            w_occ_nxt  = OCC_TWO;
          end else if (w_pop) begin
            w_occ_nxt = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (w_pop) begin
            w_head_nxt = r_skid;
            if (w_cap) begin
              w_skid_nxt = fifo_data;
            end else begin
              w_occ_nxt = OCC_ONE;
            end
          end
        end
        default: w_occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  // State, buffer, in-flight tracking and delivered-word counter.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_occ      <= OCC_EMPTY;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= fifo_r_en;
      r_drop     <= flush & r_inflight;
      r_head     <= w_head_nxt;
      r_skid     <= w_skid_nxt;
      if (w_pop) begin
        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // The read-issue rule guarantees a full buffer never receives a word without a pop.
  a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
    !((r_occ == OCC_TWO) && w_cap && !w_pop));

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Self-checking bench for fifo_rd_prefetch: a queue-based FIFO and a stream
// reference model predict every output each cycle.
module tb_fifo_rd_prefetch;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_r_en;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_cnt;

  fifo_rd_prefetch #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .word_cnt   (word_cnt)
  );

  always #5 rclk = ~rclk;

  logic [DW-1:0] fq[$];   // words sitting in the FIFO
  logic [DW-1:0] exq[$];  // words the stream still owes, in order
  logic [DW-1:0] pend;    // word read from the FIFO, arriving this cycle
  bit            pend_v;
  int unsigned   cnt;
  int            ncmp;
  int            nfail;
  int            nreads;
  bit            s_ren;
  bit            s_pop;
  bit            s_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
  endtask

  task automatic model_reset();
    exq.delete();
    pend_v = 1'b0;
    cnt    = 0;
  endtask

  // One clock cycle: predict and check at negedge, advance FIFO/model after posedge.
  task automatic tick();
    int lvl;
    bit mp;
    fifo_empty = (fq.size() == 0);
    @(negedge rclk);
    mp  = (exq.size() != 0) && m_ready;
    lvl = int'(exq.size()) + int'(pend_v) - int'(mp);
    chk("r_en", 32'(fifo_r_en), 32'(rrst_n && !fifo_empty && !flush && (lvl < 2)));
    chk("m_valid", 32'(m_valid), 32'(exq.size() != 0));
    if (exq.size() != 0) chk("m_data", 32'(m_data), 32'(exq[0]));
    chk("word_cnt", 32'(word_cnt), cnt % 16);
    s_ren   = fifo_r_en;
    s_pop   = m_valid && m_ready;
    s_flush = flush;
    if (s_ren) nreads++;
    @(posedge rclk);
    #1;
    if (s_pop) begin
      cnt++;
      if (exq.size() != 0) void'(exq.pop_front());
    end
    if (s_flush) exq.delete();
    else if (pend_v) exq.push_back(pend);
    pend_v = s_ren;
    if (s_ren) begin
      chk("rd_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        pend      = fq.pop_front();
        fifo_data = pend;
      end
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset_pulse(input string tag);
    #2;
    rrst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(word_cnt), 32'd0);
    chk({tag, "_ren"}, 32'(fifo_r_en), 32'd0);
    repeat (3) tick();
    rrst_n = 1'b1;
  endtask

  initial begin
    ncmp = 0; nfail = 0; nreads = 0; cnt = 0;
    pend = '0; pend_v = 1'b0;
    rrst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_data = '0; fifo_empty = 1'b1;

    // Reset and idle with an empty FIFO.
    repeat (3) tick();
    rrst_n = 1'b1;
    repeat (10) tick();
    chk("reset_mdata", 32'(m_data), 32'd0);

    // Three words streamed with m_ready high.
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    repeat (6) tick();
    chk("cnt_three", 32'(word_cnt), 32'd3);

    // Backpressure: only two reads, head holds.
    m_ready = 1'b0;
    push(8'h44); push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    nreads = 0;
    repeat (8) tick();
    chk("bp_reads", 32'(nreads), 32'd2);
    chk("bp_hold", 32'(m_data), 32'h44);
    m_ready = 1'b1;
    repeat (10) tick();
    chk("bp_cnt", 32'(word_cnt), 32'd8);

    // Flush the cycle after a read: that word is dropped.
    m_ready = 1'b0;
    push(8'hA0); push(8'hB0);
    tick();
    chk("flush_ren_seen", 32'(s_ren), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_mvalid", 32'(m_valid), 32'd0);
    repeat (4) tick();
    chk("flush_next_valid", 32'(m_valid), 32'd1);
    chk("flush_next_word", 32'(m_data), 32'hB0);
    m_ready = 1'b1;
    repeat (4) tick();

    // Counter wrap at 4 bits: 17 words -> 1.
    async_reset_pulse("rst1");
    for (int i = 0; i < 17; i++) push(8'(i + 8'h60));
    repeat (25) tick();
    chk("cnt_wrap", 32'(word_cnt), 32'd1);

    // Randomized traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) push(8'($urandom));
      m_ready = ($urandom_range(3) != 0);
      flush   = ($urandom_range(24) == 0);
      tick();
    end
    flush = 1'b0;
    m_ready = 1'b1;
    repeat (20) tick();

    // Reset with the buffer full, then resume from the remaining FIFO words.
    m_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    repeat (6) tick();
    chk("two_full_valid", 32'(m_valid), 32'd1);
    async_reset_pulse("rst2");
    m_ready = 1'b1;
    repeat (10) tick();
    chk("resume_cnt", 32'(word_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
